// File: rtl/local_mem_weight_param.sv
// Parametrised CNN weight store: sequential write stream through an auto-incrementing
// pointer, lane-packed strided vector reads (optionally dual) and a clear sequencer.
module local_mem_weight_param #(
    parameter int DATA_W      = 16,
    parameter int LANES       = 8,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 16,
    parameter int DUAL_OFFSET = 200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_clear,
    output logic                         busy,
    input  logic                         wr_load,
    input  logic [ADDR_W-1:0]            wr_base,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [ADDR_W-1:0]            wr_ptr,
    output logic                         wr_full,
    output logic                         wr_ovf,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [$clog2(LANES+1)-1:0]   rd_chan,
    input  logic                         rd_dual,
    output logic                         rd_valid,
    output logic [LANES*DATA_W-1:0]      rd_data1,
    output logic [LANES*DATA_W-1:0]      rd_data2,
    output logic                         rd_err
);
    localparam int CW    = $clog2(LANES + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = ADDR_W + CW;
    localparam int EW    = BW + 1;
    localparam int NVEC  = DEPTH / LANES;
    localparam int CLR_W = (NVEC > 1) ? $clog2(NVEC) : 1;

    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(NVEC - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [EW-1:0]     DEPTH_E  = EW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [CLR_W-1:0]    clr_idx_r, clr_idx_s;
    logic                busy_r;
    logic                accept_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [AW-1:0]       clr_addr_s [LANES];

    logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_s;
    logic                wr_ovf_r, wr_ovf_s;
    logic                wr_do_s;
    logic [AW-1:0]       wr_addr_s;

    logic [BW-1:0]       base_s;
    logic                chan_ok_s;
    logic [EW-1:0]       lane_a1_s [LANES];
    logic [EW-1:0]       lane_a2_s [LANES];
    logic [LANES*DATA_W-1:0] data1_s, data2_s;
    logic                err_s;
    logic                rd_valid_r, rd_err_r;
    logic [LANES*DATA_W-1:0] rd_data1_r, rd_data2_r;

    // mem_clear in IDLE takes the cycle; reads and writes then wait until the clear ends
    assign accept_s = (state_r == ST_IDLE) && !mem_clear;

    // FSM state and clear index register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= '0;
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            clr_idx_r <= clr_idx_s;
            busy_r    <= (state_s == ST_CLEAR);
        end
    end

    // FSM next state
    always_comb begin
        state_s   = state_r;
        clr_idx_s = clr_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_clear) begin
                    state_s   = ST_CLEAR;
                    clr_idx_s = '0;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_idx_r == CLR_LAST) begin
                    state_s   = ST_IDLE;
                    clr_idx_s = '0;
                end else begin
                    clr_idx_s = clr_idx_r + CLR_W'(1);
                end
            end
            default: begin
                state_s   = ST_CLEAR;
                clr_idx_s = '0;
            end
        endcase
    end

    // Word addresses zeroed by the current clear step
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            clr_addr_s[i] = AW'(clr_idx_r) * AW'(LANES) + AW'(i);
        end
    end

    // Write pointer / overflow next state; a load resets the overflow flag
    always_comb begin
        wr_do_s   = 1'b0;
        wr_addr_s = '0;
        wr_ptr_s  = wr_ptr_r;
        wr_ovf_s  = wr_ovf_r;
        if (accept_s && wr_load) begin
            wr_ptr_s = wr_base;
            wr_ovf_s = 1'b0;
            if (wr_en) begin
                if (wr_base < DEPTH_A) begin
                    wr_do_s   = 1'b1;
                    wr_addr_s = wr_base[AW-1:0];
                    wr_ptr_s  = wr_base + ADDR_W'(1);
                end else begin
                    wr_ovf_s  = 1'b1;
                end
            end else begin
                wr_do_s = 1'b0;
            end
        end else if (accept_s && wr_en) begin
            if (wr_ptr_r < DEPTH_A) begin
                wr_do_s   = 1'b1;
                wr_addr_s = wr_ptr_r[AW-1:0];
                wr_ptr_s  = wr_ptr_r + ADDR_W'(1);
            end else begin
                wr_ovf_s  = 1'b1;
            end
        end else begin
            wr_do_s = 1'b0;
        end
    end

    // Write pointer and overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            wr_ovf_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            wr_ovf_r <= wr_ovf_s;
        end
    end

    // Weight array: clear sequencer has priority over the write port
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            for (int i = 0; i < LANES; i++) begin
                mem_r[clr_addr_s[i]] <= '0;
            end
        end else if (wr_do_s) begin
            mem_r[wr_addr_s] <= wr_data;
        end
    end

    assign base_s    = BW'(rd_addr) * BW'(rd_chan);
    assign chan_ok_s = (rd_chan != '0) && (rd_chan <= CW'(LANES));

    // Lane gather for both vectors with range checking
    always_comb begin
        data1_s = '0;
        data2_s = '0;
        err_s   = !chan_ok_s;
        for (int i = 0; i < LANES; i++) begin
            lane_a1_s[i] = EW'(base_s) + EW'(i);
            lane_a2_s[i] = EW'(base_s) + EW'(i) + EW'(DUAL_OFFSET);
            if (chan_ok_s && (CW'(i) < rd_chan)) begin
                if (lane_a1_s[i] < DEPTH_E) begin
                    data1_s[i*DATA_W +: DATA_W] = mem_r[lane_a1_s[i][AW-1:0]];
                end else begin
                    err_s = 1'b1;
                end
                if (rd_dual) begin
                    if (lane_a2_s[i] < DEPTH_E) begin
                        data2_s[i*DATA_W +: DATA_W] = mem_r[lane_a2_s[i][AW-1:0]];
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    data2_s[i*DATA_W +: DATA_W] = '0;
                end
            end else begin
                data1_s[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

    // Registered read response; outputs are zero whenever no response is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_data1_r <= '0;
            rd_data2_r <= '0;
            rd_err_r   <= 1'b0;
        end else if (accept_s && rd_req) begin
            rd_valid_r <= 1'b1;
            rd_data1_r <= data1_s;
            rd_data2_r <= data2_s;
            rd_err_r   <= err_s;
        end else begin
            rd_valid_r <= 1'b0;
            rd_data1_r <= '0;
            rd_data2_r <= '0;
            rd_err_r   <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign wr_ptr   = wr_ptr_r;
    assign wr_full  = (wr_ptr_r >= DEPTH_A);
    assign wr_ovf   = wr_ovf_r;
    assign rd_valid = rd_valid_r;
    assign rd_data1 = rd_data1_r;
    assign rd_data2 = rd_data2_r;
    assign rd_err   = rd_err_r;

endmodule

// File: tb/tb_local_mem_weight_param.sv
// Directed self-checking bench for local_mem_weight_param (default parameters).
module tb_local_mem_weight_param;
    logic          clk = 1'b0;
    logic          rst, mem_clear, busy;
    logic          wr_load, wr_en, wr_full, wr_ovf;
    logic [15:0]   wr_base, wr_data, wr_ptr;
    logic          rd_req, rd_dual, rd_valid, rd_err;
    logic [15:0]   rd_addr;
    logic [3:0]    rd_chan;
    logic [127:0]  rd_data1, rd_data2;

    int total = 0;
    int bad   = 0;
    int cnt, vcnt;
    logic [127:0] exp_v;

    local_mem_weight_param dut (
        .clk(clk), .rst(rst), .mem_clear(mem_clear), .busy(busy),
        .wr_load(wr_load), .wr_base(wr_base), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ptr(wr_ptr), .wr_full(wr_full), .wr_ovf(wr_ovf),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_chan(rd_chan), .rd_dual(rd_dual),
        .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_read(input logic [15:0] a, input logic [3:0] c, input logic d);
        rd_req  = 1'b1;
        rd_addr = a;
        rd_chan = c;
        rd_dual = d;
        tick();
        rd_req  = 1'b0;
        rd_dual = 1'b0;
    endtask

    // lanes 0..n-1 hold first, first+1, ...; the rest are zero
    function automatic logic [127:0] ramp(input int first, input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*16 +: 16] = 16'(first + i);
        return v;
    endfunction

    task automatic count_busy(input logic with_traffic);
        cnt  = 0;
        vcnt = 0;
        rd_req  = with_traffic;
        rd_addr = 16'd1;
        rd_chan = 4'd8;
        wr_en   = with_traffic;
        wr_data = 16'h7777;
        while (busy && cnt < 300) begin
            cnt++;
            if (rd_valid) vcnt++;
            tick();
        end
        rd_req = 1'b0;
        wr_en  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_clear = 1'b0; wr_load = 1'b0; wr_en = 1'b0;
        wr_base = 16'd0; wr_data = 16'd0; rd_req = 1'b0; rd_addr = 16'd0;
        rd_chan = 4'd0; rd_dual = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b1);
        chk("rst_wr_ptr", wr_ptr, 16'd0);
        chk("rst_wr_ovf", wr_ovf, 1'b0);
        chk("rst_wr_full", wr_full, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);

        cnt = 0;
        for (int k = 0; k < 130; k++) begin
            if (busy) cnt++;
            tick();
        end
        chk("init_busy_cycles", 32'(cnt), 32'd128);

        do_read(16'd0, 4'd8, 1'b0);
        chk("init_rd_valid", rd_valid, 1'b1);
        chk("init_rd_data1", rd_data1, 128'd0);
        chk("init_rd_err", rd_err, 1'b0);
        tick();
        chk("valid_one_cycle", rd_valid, 1'b0);

        // stream 1..24 from address 0
        wr_load = 1'b1; wr_base = 16'd0;
        tick();
        wr_load = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            wr_en = 1'b1; wr_data = 16'(k);
            tick();
        end
        wr_en = 1'b0;
        chk("stream_wr_ptr", wr_ptr, 16'd24);

        // back-to-back reads
        rd_req = 1'b1; rd_addr = 16'd2; rd_chan = 4'd3;
        tick();
        rd_addr = 16'd1; rd_chan = 4'd8;
        chk("b2b_valid0", rd_valid, 1'b1);
        chk("rd_a2_c3", rd_data1, ramp(7, 3));
        tick();
        rd_req = 1'b0;
        chk("b2b_valid1", rd_valid, 1'b1);
        chk("rd_a1_c8", rd_data1, ramp(9, 8));
        chk("rd_a1_c8_data2", rd_data2, 128'd0);

        // dual vector
        wr_load = 1'b1; wr_en = 1'b1; wr_base = 16'd200; wr_data = 16'hA5A5;
        tick();
        wr_base = 16'd207; wr_data = 16'h5A5A;
        tick();
        wr_load = 1'b0; wr_en = 1'b0;
        do_read(16'd0, 4'd8, 1'b1);
        exp_v = '0;
        exp_v[15:0]    = 16'hA5A5;
        exp_v[127:112] = 16'h5A5A;
        chk("dual_data1", rd_data1, ramp(1, 8));
        chk("dual_data2", rd_data2, exp_v);
        chk("dual_err", rd_err, 1'b0);

        // channel-count boundaries
        do_read(16'd0, 4'd0, 1'b0);
        chk("chan0_err", rd_err, 1'b1);
        chk("chan0_data", rd_data1, 128'd0);
        do_read(16'd0, 4'd9, 1'b0);
        chk("chan9_err", rd_err, 1'b1);

        // overflow at the top of the array
        wr_load = 1'b1; wr_base = 16'd1022;
        tick();
        wr_load = 1'b0;
        wr_en = 1'b1; wr_data = 16'h1111;
        tick();
        wr_data = 16'h2222;
        tick();
        chk("top_wr_ptr", wr_ptr, 16'd1024);
        chk("top_wr_full", wr_full, 1'b1);
        chk("top_ovf_before", wr_ovf, 1'b0);
        wr_data = 16'h3333;
        tick();
        wr_en = 1'b0;
        chk("ovf_set", wr_ovf, 1'b1);
        chk("ovf_ptr_held", wr_ptr, 16'd1024);
        do_read(16'd127, 4'd8, 1'b0);
        exp_v = '0;
        exp_v[111:96]  = 16'h1111;
        exp_v[127:112] = 16'h2222;
        chk("last_vec_data", rd_data1, exp_v);
        chk("last_vec_err", rd_err, 1'b0);
        do_read(16'd128, 4'd8, 1'b0);
        chk("oob_data", rd_data1, 128'd0);
        chk("oob_err", rd_err, 1'b1);
        wr_load = 1'b1; wr_base = 16'd0;
        tick();
        wr_load = 1'b0;
        chk("load_clears_ovf", wr_ovf, 1'b0);
        chk("load_clears_full", wr_full, 1'b0);

        // load and write in the same cycle
        wr_load = 1'b1; wr_en = 1'b1; wr_base = 16'd50; wr_data = 16'h1234;
        tick();
        wr_load = 1'b0; wr_en = 1'b0;
        chk("loadwr_ptr", wr_ptr, 16'd51);
        do_read(16'd50, 4'd1, 1'b0);
        chk("loadwr_data", rd_data1, 128'h1234);

        // read-during-write returns the old word
        wr_en = 1'b1; wr_data = 16'hBEEF;
        rd_req = 1'b1; rd_addr = 16'd51; rd_chan = 4'd1;
        tick();
        wr_en = 1'b0; rd_req = 1'b0;
        chk("rdw_old", rd_data1, 128'd0);
        chk("rdw_ptr", wr_ptr, 16'd52);
        do_read(16'd51, 4'd1, 1'b0);
        chk("rdw_new", rd_data1, 128'hBEEF);

        // clear with traffic during busy
        mem_clear = 1'b1;
        tick();
        mem_clear = 1'b0;
        count_busy(1'b1);
        chk("clr_busy_cycles", 32'(cnt), 32'd128);
        chk("clr_no_valid", 32'(vcnt), 32'd0);
        chk("clr_ptr_held", wr_ptr, 16'd52);
        tick();
        chk("clr_done_valid", rd_valid, 1'b0);
        do_read(16'd1, 4'd8, 1'b1);
        chk("clr_data1", rd_data1, 128'd0);
        chk("clr_data2", rd_data2, 128'd0);
        do_read(16'd6, 4'd8, 1'b0);
        chk("clr_data_50", rd_data1, 128'd0);

        // reset in the middle of a clear restarts it
        mem_clear = 1'b1;
        tick();
        mem_clear = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midclr_ptr", wr_ptr, 16'd0);
        count_busy(1'b0);
        chk("midclr_busy_cycles", 32'(cnt), 32'd128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/local_mem_weight_param.md
Name: local_mem_weight_param

Overview:
Parametrised weight store for the CNN datapath. The weight loader fills it as a sequential word stream through an auto-incrementing write pointer. Convolution and FC stages read a lane-packed vector of up to LANES weights per request, with a runtime-selected channel stride. It replaces the fixed 3/8-channel local weight memory and adds:
- a registered read with a valid strobe;
- a dual-vector read at a parametrised offset;
- write overflow and read range checks;
- a hardware clear sequencer.

Parameters:
DATA_W, 16, bits per weight word
LANES, 8, maximum weights returned per read vector
DEPTH, 1024, total weight words; must be a multiple of LANES
ADDR_W, 16, width of all address and pointer ports
DUAL_OFFSET, 200, word offset of the second vector in dual reads (FC layer)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
mem_clear  in  1  pulse: zero the whole array
busy  out  1  high while clearing
wr_load  in  1  load the write pointer from wr_base
wr_base  in  ADDR_W  write pointer load value
wr_en  in  1  write wr_data at the write pointer, then increment the pointer
wr_data  in  DATA_W  weight word
wr_ptr  out  ADDR_W  current write pointer
wr_full  out  1  wr_ptr >= DEPTH
wr_ovf  out  1  sticky: a write was dropped because the array was full
rd_req  in  1  read request
rd_addr  in  ADDR_W  vector index
rd_chan  in  $clog2(LANES+1)  channels per vector (1..LANES); also the stride
rd_dual  in  1  also fetch the second vector
rd_valid  out  1  rd_data1/rd_data2 are valid this cycle
rd_data1  out  LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W]
rd_data2  out  LANES*DATA_W  second vector; zero unless rd_dual
rd_err  out  1  qualified by rd_valid: request was out of range or rd_chan==0

Behaviour:
- Reset (rst=1 at a rising edge):
  - all outputs 0 except busy=1;
  - wr_ptr=0, wr_ovf=0;
  - the FSM enters CLEAR with clr_idx=0;
  - reset asserted mid-clear or mid-read restarts CLEAR and drops any pending read.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on mem_clear.
  - In CLEAR, each cycle zeroes words [clr_idx*LANES, clr_idx*LANES+LANES-1] and increments clr_idx.
  - CLEAR -> IDLE after the cycle with clr_idx == DEPTH/LANES-1. With DEPTH=1024 and LANES=8, busy is high for exactly 128 cycles.
  - mem_clear during CLEAR is ignored.
- While busy:
  - wr_en, wr_load and rd_req are ignored;
  - rd_valid=0;
  - wr_ptr is held.
- Write path (IDLE only):
  - wr_load alone: wr_ptr <= wr_base and wr_ovf <= 0.
  - wr_load with wr_en in the same cycle: load wins. mem[wr_base] is written and wr_ptr <= wr_base+1.
  - wr_en with wr_ptr < DEPTH: mem[wr_ptr] is written and wr_ptr increments.
  - wr_en with wr_ptr >= DEPTH: the write is dropped, wr_ovf <= 1 and the pointer is held.
  - wr_full is combinational from wr_ptr.
- Read path (IDLE only):
  - Latency 1. A request sampled at edge N gives rd_valid=1 with data after edge N, for one cycle per request. Back-to-back requests give back-to-back valids.
  - base = rd_addr * rd_chan, computed at ADDR_W+$clog2(LANES+1) bits with no truncation.
  - Lane i, for i < rd_chan, = mem[base+i]. Lanes i >= rd_chan = 0.
  - If rd_dual: rd_data2 lane i = mem[base+DUAL_OFFSET+i] under the same lane rule. Otherwise rd_data2 = 0.
  - Any valid lane address >= DEPTH reads as 0 and sets rd_err=1 for that response.
  - rd_chan == 0 or rd_chan > LANES: both vectors are 0 and rd_err=1.
  - When rd_valid=0, rd_data1, rd_data2 and rd_err are 0.
- Read-during-write to the same word in the same cycle returns the old data.
- The array is inferred as registers or flops (no SRAM macro). Only clear and writes modify it; reset does so indirectly via CLEAR.

Test Plan:
- Reset, then idle 130 cycles -> busy high for exactly 128 cycles. Then a read with rd_addr=0, rd_chan=8 -> rd_valid one cycle later, rd_data1 = 0, rd_err=0.
- wr_load with wr_base=0, then stream 24 writes of values 1..24 -> wr_ptr=24. Read rd_addr=2, rd_chan=3 -> lanes 0..2 = 7, 8, 9, lanes 3..7 = 0. Read rd_addr=1, rd_chan=8 -> lanes = 9..16.
- Write value 0xA5A5 at address 200 and 0x5A5A at address 207 via wr_load/wr_en. Read rd_addr=0, rd_chan=8, rd_dual=1 -> rd_data2 lane 0 = 0xA5A5, lane 7 = 0x5A5A.
- wr_load with wr_base=1022, then 3 writes -> first two land at 1022 and 1023, wr_full=1, third dropped, wr_ovf=1. Read rd_addr=127, rd_chan=8 -> rd_err=0. Read rd_addr=128 -> rd_data1 = 0, rd_err=1. A later wr_load clears wr_ovf.
- wr_load with wr_base=50 and wr_en with data 0x1234 in the same cycle -> mem[50]=0x1234, wr_ptr=51. Write address 51 and read it in the same cycle -> read returns the old value.
- mem_clear after filling data, with rd_req asserted during clear -> no rd_valid during the 128 busy cycles, then all reads return 0. Assert rst at clear cycle 40 -> busy stays high for another 128 cycles.
